capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Sequencing controller around the trigger unit and the sample memory of the logic analyzer. Once armed, it streams samples into a circular buffer and waits for the trigger's run flag. After the trigger it captures a configured number of post-trigger samples, then reads a configured number of samples back, newest first, over a valid/ready handshake to the transmitter. It sits between the command decoder, the trigger, the sample RAM and the UART TX path.

## Interface
Parameters:
- `ADDR_W`, default 10: sample memory address width; depth = 2^ADDR_W words of 32 bits.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  system reset; synchronous, active-high.
- `cmd_i`  in  32  command payload. `[15:0]` is the read field R; `[31:16]` is the delay field D.
- `set_cnt_i`  in  1  latch R and D from `cmd_i`.
- `arm_i`  in  1  arm request; same pulse drives the trigger.
- `abort_i`  in  1  abort any capture or readout.
- `run_i`  in  1  trigger fired, from the trigger unit.
- `stb_i`  in  1  new sample valid.
- `smpls_i`  in  32  sample word.
- `we_o`  out  1  memory write enable.
- `waddr_o`  out  ADDR_W  memory write address.
- `wdata_o`  out  32  memory write data.
- `raddr_o`  out  ADDR_W  memory read address; the RAM has 1-cycle read latency.
- `rdata_i`  in  32  memory read data.
- `tx_vld_o`  out  1  readout word valid.
- `tx_data_o`  out  32  readout word.
- `tx_rdy_i`  in  1  transmitter accepts the word.
- `armed_o`  out  1  high in ARMED.
- `busy_o`  out  1  high in any state except IDLE.

## Operation
- **Sample counts.** Post-trigger count NDLY = (D+1)*4. Readout count NRD = (R+1)*4. Both are 18-bit unsigned values.
- **Reset values.** R = D = 0, giving NDLY = NRD = 4 after reset.
- **Loading counts.** `set_cnt_i` loads R and D only in IDLE; in every other state it is ignored.
- **States:** IDLE, ARMED, DELAY, RD_REQ, RD_WAIT, RD_OUT.
- **IDLE.** `arm_i` moves to ARMED. The write pointer `wptr` is not cleared.
- **ARMED.** Every `stb_i` writes `smpls_i` to `wptr`, then `wptr` increments modulo depth. `run_i` moves to DELAY and clears the delay counter. A sample strobed in the same cycle as `run_i` is written but not counted.
- **DELAY.** Every `stb_i` writes and increments the delay counter. The write that brings the count to NDLY moves to RD_REQ. At that point `rptr` = `wptr`−1 (post-increment value, modulo depth) and the remaining counter = NRD.
- **RD_REQ.** Drive `raddr_o` = `rptr`; go to RD_WAIT.
- **RD_WAIT.** Capture `rdata_i` into `tx_data_o`, set `tx_vld_o`, go to RD_OUT.
- **RD_OUT.** Hold `tx_vld_o` and `tx_data_o` stable until `tx_rdy_i`. On the handshake: clear `tx_vld_o`, decrement remaining, decrement `rptr` modulo depth. If remaining reaches 0 go to IDLE, otherwise go to RD_REQ.
- **Write port.** `we_o` = `stb_i` while in ARMED or DELAY; it is combinational. `waddr_o` = `wptr`. `wdata_o` = `smpls_i`. `stb_i` in any other state is dropped.
- **Readout wrap.** If NRD exceeds depth, `rptr` wraps and older or stale words repeat. There is no clamping.
- **Ignored inputs.** `arm_i` outside IDLE is ignored. `run_i` outside ARMED is ignored.
- **Abort.** `abort_i` in any state moves to IDLE next cycle and clears `tx_vld_o`. R, D and `wptr` are kept.
- **Reset.** `rst_i` overrides `abort_i`. It clears state, pointers, counters, R, D and `tx_vld_o`. This applies mid-capture and mid-readout alike.

## Timing
- Output values while `rst_i` is high at a clock edge, and on the following cycle:
  - `we_o` = 0
  - `waddr_o` = 0
  - `raddr_o` = 0
  - `tx_vld_o` = 0
  - `tx_data_o` = 0
  - `armed_o` = 0
  - `busy_o` = 0
- `arm_i` high at edge n: `armed_o` and `busy_o` are high after edge n. `arm_i` and `stb_i` in the same cycle: that sample is not written.
- `run_i` at edge n: state is DELAY after edge n.
- The NDLY-th counted write at edge n: RD_REQ after n. The first `tx_vld_o` rises after n+2.
- Readout costs 3 cycles per word with `tx_rdy_i` tied high, i.e. 3·NRD cycles total. A stalled `tx_rdy_i` extends RD_OUT indefinitely with data held.
- The last handshake at edge n: state is IDLE and `busy_o` = 0 after n.

## Test plan
- **Reset and defaults.** After `rst_i`, arm, pulse `run_i`, send 4 strobes of 0x10..0x13. Required: transition to readout, then exactly 4 words out, 0x13, 0x12, 0x11, 0x10, in that order.
- **Configured counts.** `cmd_i`=0x0001_0000 with `set_cnt_i` (NDLY=8, NRD=4), ADDR_W=4. Fill 20 strobes pre-trigger, trigger, 8 strobes. Required: exactly 8 writes counted in DELAY, readout = last 4 written values newest first, `wptr` has wrapped.
- **Backpressure.** Hold `tx_rdy_i` low 5 cycles on word 2. Required: `tx_vld_o`=1 and `tx_data_o` constant throughout; no word lost or duplicated.
- **Simultaneous events.** `run_i` together with `stb_i`: that sample is written, and DELAY then needs NDLY further strobes. Separately, `set_cnt_i` during ARMED: counts unchanged. Separately, `arm_i` during RD_OUT: ignored.
- **Abort and reset mid-operation.** `abort_i` in DELAY: IDLE next cycle, `we_o` stays 0 on later strobes. `rst_i` during RD_OUT: `tx_vld_o` = 0 next cycle, R/D back to 0.
- **Read wrap.** ADDR_W=3, NRD=12: `raddr_o` sequence wraps 7→0 descending and words repeat with period 8.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl: arm / pre-trigger fill / post-trigger delay / newest-first
// readout sequencer between trigger unit, sample RAM and UART TX path.
module capture_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cmd_i,
  input  logic              set_cnt_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              run_i,
  input  logic              stb_i,
  input  logic [31:0]       smpls_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic [31:0]       rdata_i,
  output logic              tx_vld_o,
  output logic [31:0]       tx_data_o,
  input  logic              tx_rdy_i,
  output logic              armed_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    RD_REQ,
    RD_WAIT,
    RD_OUT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wptr, wptr_n;
  logic [ADDR_W-1:0] rptr, rptr_n;
  logic [17:0]       dcnt, dcnt_n, dcnt_inc;
  logic [17:0]       rem, rem_n;
  logic [17:0]       ndly, nrd;
  logic [15:0]       r_fld, r_fld_n;
  logic [15:0]       d_fld, d_fld_n;
  logic              tx_vld, tx_vld_n;
  logic [31:0]       tx_data, tx_data_n;
  logic              wr_en;

  // (field+1)*4 in 18 bits; field=0xFFFF wraps to 0, i.e. 2^18 samples.
  assign ndly     = {d_fld, 2'b00} + 18'd4;
  assign nrd      = {r_fld, 2'b00} + 18'd4;
  assign dcnt_inc = dcnt + 18'd1;

  // Samples are only written while capturing; elsewhere strobes are dropped.
  assign wr_en = stb_i && !rst_i && ((state == ARMED) || (state == DELAY));

  assign we_o      = wr_en;
  assign waddr_o   = wptr;
  assign wdata_o   = smpls_i;
  assign raddr_o   = rptr;
  assign tx_vld_o  = tx_vld;
  assign tx_data_o = tx_data;
  assign armed_o   = (state == ARMED);
  assign busy_o    = (state != IDLE);

  // Next-state and datapath updates; defaults hold every register.
  always_comb begin
    state_n   = state;
    wptr_n    = wptr;
    rptr_n    = rptr;
    dcnt_n    = dcnt;
    rem_n     = rem;
    r_fld_n   = r_fld;
    d_fld_n   = d_fld;
    tx_vld_n  = tx_vld;
    tx_data_n = tx_data;

    if (wr_en) begin
      wptr_n = wptr + 1'b1;
    end

    case (state)
      IDLE: begin
        if (set_cnt_i) begin
          r_fld_n = cmd_i[15:0];
          d_fld_n = cmd_i[31:16];
        end
        if (arm_i) begin
          state_n = ARMED;
        end
      end
      ARMED: begin
        // A sample in the trigger cycle is stored but not counted.
        if (run_i) begin
          state_n = DELAY;
          dcnt_n  = '0;
        end
      end
      DELAY: begin
        if (stb_i) begin
          dcnt_n = dcnt_inc;
          if (dcnt_inc == ndly) begin
            state_n = RD_REQ;
            rptr_n  = wptr;
            rem_n   = nrd;
          end
        end
      end
      RD_REQ: begin
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        tx_data_n = rdata_i;
        tx_vld_n  = 1'b1;
        state_n   = RD_OUT;
      end
      RD_OUT: begin
        if (tx_rdy_i) begin
          tx_vld_n = 1'b0;
          rem_n    = rem - 18'd1;
          rptr_n   = rptr - 1'b1;
          state_n  = (rem == 18'd1) ? IDLE : RD_REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (abort_i) begin
      state_n  = IDLE;
      tx_vld_n = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      dcnt    <= '0;
      rem     <= '0;
      r_fld   <= '0;
      d_fld   <= '0;
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_n;
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      dcnt    <= dcnt_n;
      rem     <= rem_n;
      r_fld   <= r_fld_n;
      d_fld   <= d_fld_n;
      tx_vld  <= tx_vld_n;
      tx_data <= tx_data_n;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with a depth-8 sample RAM.
module tb_capture_ctrl;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cmd = '0;
  logic          set_cnt = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          run = 1'b0;
  logic          stb = 1'b0;
  logic [31:0]   smpls = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          tx_vld;
  logic [31:0]   tx_data;
  logic          tx_rdy = 1'b1;
  logic          armed;
  logic          busy;

  logic [31:0]   mem [8];
  logic [31:0]   exp_d [$];
  logic [31:0]   exp_a [$];
  int            n_cmp = 0;
  int            n_err = 0;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cmd_i     (cmd),
    .set_cnt_i (set_cnt),
    .arm_i     (arm),
    .abort_i   (abort),
    .run_i     (run),
    .stb_i     (stb),
    .smpls_i   (smpls),
    .we_o      (we),
    .waddr_o   (waddr),
    .wdata_o   (wdata),
    .raddr_o   (raddr),
    .rdata_i   (rdata),
    .tx_vld_o  (tx_vld),
    .tx_data_o (tx_data),
    .tx_rdy_i  (tx_rdy),
    .armed_o   (armed),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  // Sample RAM with one cycle read latency.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] v);
    stb = 1'b1;
    smpls = v;
    step();
    stb = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic load_cnt(input logic [31:0] c);
    cmd = c; set_cnt = 1'b1; step(); set_cnt = 1'b0;
  endtask

  // Collects n words starting in RD_REQ; optionally stalls word stall_at.
  task automatic drain(input int n, input int stall_at, input int stall_len);
    int got_n, cyc, stalled;
    got_n = 0; cyc = 0; stalled = 0;
    while (got_n < n && cyc < 3 * n + stall_len + 20) begin
      if (tx_vld) begin
        if (got_n == stall_at && stalled < stall_len) begin
          tx_rdy = 1'b0;
          check_eq("stall_data", tx_data, exp_d[0]);
          stalled++;
        end else begin
          tx_rdy = 1'b1;
          check_eq("rd_data", tx_data, exp_d.pop_front());
          if (exp_a.size() > 0) check_eq("rd_addr", {29'd0, raddr}, exp_a.pop_front());
          got_n++;
        end
      end else begin
        tx_rdy = 1'b1;
      end
      step();
      cyc++;
    end
    check_eq("rd_count", got_n, n);
    check_eq("rd_cycles", cyc, 3 * n + stall_len);
    check_eq("busy_end", {31'd0, busy}, 32'd0);
    exp_d.delete();
    exp_a.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset and defaults
    step(); step();
    check_eq("rst_we", {31'd0, we}, 0);
    check_eq("rst_waddr", {29'd0, waddr}, 0);
    check_eq("rst_raddr", {29'd0, raddr}, 0);
    check_eq("rst_vld", {31'd0, tx_vld}, 0);
    check_eq("rst_data", tx_data, 0);
    check_eq("rst_armed", {31'd0, armed}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_busy", {31'd0, busy}, 0);
    arm = 1'b1; stb = 1'b1; smpls = 32'hDEAD;
    #1 check_eq("arm_stb_we", {31'd0, we}, 0);
    step(); arm = 1'b0; stb = 1'b0;
    check_eq("armed", {31'd0, armed}, 1);
    check_eq("armed_busy", {31'd0, busy}, 1);
    check_eq("arm_waddr", {29'd0, waddr}, 0);
    pulse_run();
    check_eq("delay_armed", {31'd0, armed}, 0);
    check_eq("delay_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 3; i++) strobe(32'h10 + i);
    stb = 1'b1; smpls = 32'h13;
    #1 check_eq("delay_we", {31'd0, we}, 1);
    check_eq("delay_waddr", {29'd0, waddr}, 3);
    step(); stb = 1'b0;
    exp_d = '{32'h13, 32'h12, 32'h11, 32'h10};
    exp_a = '{32'd3, 32'd2, 32'd1, 32'd0};
    drain(4, -1, 0);

    // Configured counts, set_cnt ignored while armed, pointer wrap
    load_cnt(32'h0001_0000);
    pulse_arm();
    for (int i = 0; i < 20; i++) strobe(32'h100 + i);
    load_cnt(32'h0003_0003);
    pulse_run();
    for (int i = 0; i < 7; i++) strobe(32'h200 + i);
    step(); step(); step();
    check_eq("ndly_not_done_vld", {31'd0, tx_vld}, 0);
    check_eq("ndly_not_done_busy", {31'd0, busy}, 1);
    strobe(32'h207);
    exp_d = '{32'h207, 32'h206, 32'h205, 32'h204};
    exp_a = '{32'd7, 32'd6, 32'd5, 32'd4};
    drain(4, -1, 0);
    check_eq("wptr_wrapped", {29'd0, waddr}, 0);

    // run with stb, then backpressure on word 2
    load_cnt(32'h0000_0000);
    pulse_arm();
    strobe(32'h300);
    strobe(32'h301);
    run = 1'b1; stb = 1'b1; smpls = 32'h302;
    #1 check_eq("run_stb_we", {31'd0, we}, 1);
    step(); run = 1'b0; stb = 1'b0;
    for (int i = 3; i < 6; i++) strobe(32'h300 + i);
    step(); step(); step();
    check_eq("run_stb_uncounted", {31'd0, tx_vld}, 0);
    strobe(32'h306);
    exp_d = '{32'h306, 32'h305, 32'h304, 32'h303};
    exp_a = '{32'd6, 32'd5, 32'd4, 32'd3};
    drain(4, 1, 5);

    // arm during RD_OUT ignored
    pulse_arm();
    pulse_run();
    for (int i = 0; i < 4; i++) strobe(32'h400 + i);
    step(); step();
    check_eq("first_vld", {31'd0, tx_vld}, 1);
    check_eq("first_data", tx_data, 32'h403);
    check_eq("first_addr", {29'd0, raddr}, 2);
    tx_rdy = 1'b1; arm = 1'b1;
    step(); arm = 1'b0;
    check_eq("arm_in_rdout", {31'd0, armed}, 0);
    check_eq("vld_after_hs", {31'd0, tx_vld}, 0);
    exp_d = '{32'h402, 32'h401, 32'h400};
    exp_a = '{32'd1, 32'd0, 32'd7};
    drain(3, -1, 0);

    // abort in DELAY
    pulse_arm();
    pulse_run();
    strobe(32'h500);
    strobe(32'h501);
    abort = 1'b1; step(); abort = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 0);
    check_eq("abort_vld", {31'd0, tx_vld}, 0);
    stb = 1'b1; smpls = 32'h5FF;
    #1 check_eq("abort_we", {31'd0, we}, 0);
    step(); stb = 1'b0;
    check_eq("abort_waddr", {29'd0, waddr}, 5);
    step(); step();
    check_eq("abort_no_rd", {31'd0, tx_vld}, 0);

    // reset during RD_OUT
    load_cnt(32'h0002_0001);
    pulse_arm();
    pulse_run();
    for (int i = 0; i < 12; i++) strobe(32'h600 + i);
    step(); step();
    check_eq("pre_rst_vld", {31'd0, tx_vld}, 1);
    check_eq("pre_rst_data", tx_data, 32'h60B);
    tx_rdy = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    check_eq("mid_rst_vld", {31'd0, tx_vld}, 0);
    check_eq("mid_rst_data", tx_data, 0);
    check_eq("mid_rst_busy", {31'd0, busy}, 0);
    check_eq("mid_rst_waddr", {29'd0, waddr}, 0);
    check_eq("mid_rst_raddr", {29'd0, raddr}, 0);
    pulse_arm();
    pulse_run();
    for (int i = 0; i < 4; i++) strobe(32'h700 + i);
    exp_d = '{32'h703, 32'h702, 32'h701, 32'h700};
    exp_a = '{32'd3, 32'd2, 32'd1, 32'd0};
    drain(4, -1, 0);

    // read wrap: NRD=12 on depth 8
    load_cnt(32'h0000_0002);
    pulse_arm();
    for (int i = 0; i < 8; i++) strobe(32'h800 + i);
    pulse_run();
    for (int i = 0; i < 4; i++) strobe(32'h900 + i);
    exp_d = '{32'h903, 32'h902, 32'h901, 32'h900, 32'h807, 32'h806,
              32'h805, 32'h804, 32'h903, 32'h902, 32'h901, 32'h900};
    exp_a = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2,
              32'd1, 32'd0, 32'd7, 32'd6, 32'd5, 32'd4};
    drain(12, -1, 0);
    step();
    check_eq("wrap_no_extra", {31'd0, tx_vld}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
